// File: rtl/game_turn_ctrl.sv
// Connect4 turn sequencer: rotates 2..4 players, handles full-column retries and turn
// timeouts, and latches the win/tie verdict from the board evaluator.
module game_turn_ctrl #(
   parameter int NUM_PLAYERS  = 2,
   parameter int BOARD_CELLS  = 42,
   parameter int TURN_TIMEOUT = 0,
   parameter int MAX_RETRIES  = 3,
   localparam int PW = (NUM_PLAYERS > 2) ? 2 : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          move_req,
   input  logic          column_full,
   input  logic          eval_valid,
   input  logic [1:0]    eval_result,
   output logic [1:0]    current_state,
   output logic [PW-1:0] active_player,
   output logic [1:0]    game_status,
   output logic [PW-1:0] winner,
   output logic          move_accept,
   output logic          throw_again,
   output logic          turn_skipped,
   output logic [5:0]    move_count
);

   localparam int TW = (TURN_TIMEOUT < 2) ? 1 : $clog2(TURN_TIMEOUT + 1);
   localparam int RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_MOVE = 2'b01,
      EVAL      = 2'b10,
      END_GAME  = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] player_q, player_d;
   logic [PW-1:0] winner_q, winner_d;
   logic [1:0]    status_q, status_d;
   logic          accept_q, accept_d;
   logic          again_q, again_d;
   logic          skip_q, skip_d;
   logic [5:0]    count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] retry_q, retry_d;

   function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
      return (p == PW'(NUM_PLAYERS - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      state_d  = state_q;
      player_d = player_q;
      winner_d = winner_q;
      status_d = status_q;
      count_d  = count_q;
      timer_d  = timer_q;
      retry_d  = retry_q;
      accept_d = 1'b0;
      again_d  = 1'b0;
      skip_d   = 1'b0;
      unique case (state_q)
         IDLE, END_GAME: begin
            if (start) begin
               state_d  = WAIT_MOVE;
               player_d = '0;
               winner_d = '0;
               status_d = 2'b00;
               count_d  = '0;
               timer_d  = '0;
               retry_d  = '0;
            end
         end
         WAIT_MOVE: begin
            if (move_req && !column_full) begin
               accept_d = 1'b1;
               if (int'(count_q) < BOARD_CELLS) count_d = count_q + 1'b1;
               retry_d  = '0;
               timer_d  = '0;
               state_d  = EVAL;
            end else if (move_req) begin
               if (MAX_RETRIES != 0 && int'(retry_q) + 1 >= MAX_RETRIES) begin
                  skip_d   = 1'b1;
                  player_d = next_player(player_q);
                  retry_d  = '0;
                  timer_d  = '0;
               end else begin
                  again_d = 1'b1;
                  if (MAX_RETRIES != 0) retry_d = retry_q + 1'b1;
                  // A retry does not restart the turn clock.
                  if (int'(timer_q) < TURN_TIMEOUT) timer_d = timer_q + 1'b1;
               end
            end else if (TURN_TIMEOUT != 0) begin
               if (int'(timer_q) >= TURN_TIMEOUT - 1) begin
                  skip_d   = 1'b1;
                  player_d = next_player(player_q);
                  retry_d  = '0;
                  timer_d  = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         end
         EVAL: begin
            if (eval_valid) begin
               case (eval_result)
                  2'b00: begin
                     if (int'(count_q) >= BOARD_CELLS) begin
                        state_d  = END_GAME;
                        status_d = 2'b11;
                     end else begin
                        state_d  = WAIT_MOVE;
                        player_d = next_player(player_q);
                        timer_d  = '0;
                        retry_d  = '0;
                     end
                  end
                  2'b01: begin
                     state_d  = END_GAME;
                     status_d = 2'b01;
                     winner_d = player_q;
                  end
                  default: begin
                     state_d  = END_GAME;
                     status_d = 2'b11;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         player_q <= '0;
         winner_q <= '0;
         status_q <= '0;
         count_q  <= '0;
         timer_q  <= '0;
         retry_q  <= '0;
         accept_q <= 1'b0;
         again_q  <= 1'b0;
         skip_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         player_q <= player_d;
         winner_q <= winner_d;
         status_q <= status_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         retry_q  <= retry_d;
         accept_q <= accept_d;
         again_q  <= again_d;
         skip_q   <= skip_d;
      end
   end

   assign current_state = state_q;
   assign active_player = player_q;
   assign game_status   = status_q;
   assign winner        = winner_q;
   assign move_accept   = accept_q;
   assign throw_again   = again_q;
   assign turn_skipped  = skip_q;
   assign move_count    = count_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench for game_turn_ctrl: instance A (2 players, 4-cell board, retries 3, no
// timeout) and instance B (3 players, timeout 10), selected by sel.
module tb_game_turn_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, move_req, column_full, eval_valid;
   logic [1:0] eval_result;
   logic       sel;

   logic [1:0] a_state, a_status, b_state, b_status;
   logic       a_player, a_winner;
   logic [1:0] b_player, b_winner;
   logic       a_acc, a_again, a_skip, b_acc, b_again, b_skip;
   logic [5:0] a_count, b_count;

   logic [1:0] o_state, o_status, o_player, o_winner;
   logic       o_acc, o_again, o_skip;
   logic [5:0] o_count;

   int n_chk = 0, n_pass = 0, n_fail = 0;

   always #5 clk = ~clk;

   game_turn_ctrl #(.NUM_PLAYERS(2), .BOARD_CELLS(4), .TURN_TIMEOUT(0), .MAX_RETRIES(3)) u_a (
      .clk(clk), .reset(reset), .start(start & ~sel), .move_req(move_req & ~sel),
      .column_full(column_full), .eval_valid(eval_valid & ~sel), .eval_result(eval_result),
      .current_state(a_state), .active_player(a_player), .game_status(a_status),
      .winner(a_winner), .move_accept(a_acc), .throw_again(a_again),
      .turn_skipped(a_skip), .move_count(a_count));

   game_turn_ctrl #(.NUM_PLAYERS(3), .BOARD_CELLS(42), .TURN_TIMEOUT(10), .MAX_RETRIES(3)) u_b (
      .clk(clk), .reset(reset), .start(start & sel), .move_req(move_req & sel),
      .column_full(column_full), .eval_valid(eval_valid & sel), .eval_result(eval_result),
      .current_state(b_state), .active_player(b_player), .game_status(b_status),
      .winner(b_winner), .move_accept(b_acc), .throw_again(b_again),
      .turn_skipped(b_skip), .move_count(b_count));

   assign o_state  = sel ? b_state  : a_state;
   assign o_status = sel ? b_status : a_status;
   assign o_player = sel ? b_player : {1'b0, a_player};
   assign o_winner = sel ? b_winner : {1'b0, a_winner};
   assign o_acc    = sel ? b_acc    : a_acc;
   assign o_again  = sel ? b_again  : a_again;
   assign o_skip   = sel ? b_skip   : a_skip;
   assign o_count  = sel ? b_count  : a_count;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic st, input logic mr, input logic cf, input logic ev,
                      input logic [1:0] er);
      start = st; move_req = mr; column_full = cf; eval_valid = ev; eval_result = er;
      @(posedge clk); #1;
      start = 1'b0; move_req = 1'b0; column_full = 1'b0; eval_valid = 1'b0; eval_result = 2'b00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic mv_ev(input logic [1:0] er);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, er);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; sel = 1'b0;
      start = 1'b0; move_req = 1'b0; column_full = 1'b0; eval_valid = 1'b0; eval_result = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", o_state, 0);
      chk("rst_player", o_player, 0);
      chk("rst_status", o_status, 0);
      chk("rst_count", o_count, 0);
      reset = 1'b1;
      idle(1);

      // Instance A: basic game, retries, win
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      chk("start_state", o_state, 1);
      chk("start_player", o_player, 0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      chk("p0_accept", o_acc, 1);
      chk("p0_state_eval", o_state, 2);
      chk("p0_count", o_count, 1);
      idle(1);
      chk("accept_one_cycle", o_acc, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      chk("start_in_eval_ignored", o_state, 2);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      chk("move_in_eval_ignored", o_acc, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
      chk("next_state", o_state, 1);
      chk("next_player", o_player, 1);

      cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
      chk("retry1_again", o_again, 1);
      chk("retry1_player", o_player, 1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
      chk("retry2_again", o_again, 1);
      chk("retry2_skip", o_skip, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
      chk("retry3_again", o_again, 0);
      chk("retry3_skip", o_skip, 1);
      chk("retry3_player", o_player, 0);
      chk("retry3_state", o_state, 1);
      chk("retry3_count", o_count, 1);
      idle(1);
      chk("skip_one_cycle", o_skip, 0);

      mv_ev(2'b00);
      chk("p0b_player", o_player, 1);
      mv_ev(2'b01);
      chk("win_state", o_state, 3);
      chk("win_status", o_status, 1);
      chk("win_winner", o_winner, 1);
      chk("win_count", o_count, 3);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
      chk("end_move_ignored", o_acc, 0);
      chk("end_eval_ignored", o_status, 1);
      chk("end_count_hold", o_count, 3);

      // Full board forced tie
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      chk("restart_state", o_state, 1);
      chk("restart_status", o_status, 0);
      chk("restart_winner", o_winner, 0);
      chk("restart_count", o_count, 0);
      mv_ev(2'b00); mv_ev(2'b00); mv_ev(2'b00);
      chk("full_pre_player", o_player, 1);
      mv_ev(2'b00);
      chk("full_state", o_state, 3);
      chk("full_status", o_status, 3);
      chk("full_count", o_count, 4);
      chk("full_player_hold", o_player, 1);

      // Win on the last cell beats the full-board tie
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      mv_ev(2'b00); mv_ev(2'b00); mv_ev(2'b00);
      mv_ev(2'b01);
      chk("lastwin_status", o_status, 1);
      chk("lastwin_winner", o_winner, 1);
      chk("lastwin_count", o_count, 4);

      // Result code 11 is a tie
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      mv_ev(2'b11);
      chk("tie11_state", o_state, 3);
      chk("tie11_status", o_status, 3);
      chk("tie11_count", o_count, 1);

      // Asynchronous reset while in EVAL
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      chk("pre_rst_state", o_state, 2);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_state", o_state, 0);
      chk("async_rst_accept", o_acc, 0);
      chk("async_rst_count", o_count, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      chk("post_rst_state", o_state, 1);
      chk("post_rst_player", o_player, 0);
      chk("post_rst_count", o_count, 0);

      // Instance B: timeout rotation across three players
      sel = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      chk("b_start_state", o_state, 1);
      idle(9);
      chk("b_t9_skip", o_skip, 0);
      chk("b_t9_player", o_player, 0);
      idle(1);
      chk("b_to1_skip", o_skip, 1);
      chk("b_to1_player", o_player, 1);
      idle(10);
      chk("b_to2_skip", o_skip, 1);
      chk("b_to2_player", o_player, 2);
      idle(10);
      chk("b_to3_skip", o_skip, 1);
      chk("b_to3_player", o_player, 0);
      chk("b_no_accept", o_acc, 0);
      chk("b_no_count", o_count, 0);
      idle(9);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      chk("b_expiry_accept", o_acc, 1);
      chk("b_expiry_noskip", o_skip, 0);
      chk("b_expiry_state", o_state, 2);
      chk("b_expiry_player", o_player, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
